// File: rtl/restador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : restador_pkg
//  Description : Shared types for the bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package restador_pkg;

    // Sequencer states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

endpackage : restador_pkg
`default_nettype wire

// File: rtl/celda_resta.sv
`default_nettype none
// ============================================================================
//  Module      : celda_resta
//  Description : Combinational 1-bit full subtractor (a - b - c_in).
//  Revision    : 1.0 - initial release
// ============================================================================
module celda_resta (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic d,
    output logic c_out
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d     = a ^ b ^ c_in;
        c_out = (~a & b) | (~a & c_in) | (b & c_in);
    end

endmodule : celda_resta
`default_nettype wire

// File: rtl/restador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : restador_serial
//  Description : Bit-serial N-bit unsigned subtractor, LSB first, one bit
//                per clock through a single full-subtractor cell. Produces
//                d = (a - b) mod 2^N and the final borrow (a < b).
//  Revision    : 1.0 - initial release
// ============================================================================
module restador_serial
    import restador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         borrow
);

    localparam int            c_cnt_w    = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

    estado_t              r_state;
    estado_t              w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [N-1:0]         r_a_sh;
    logic [N-1:0]         r_b_sh;
    // Holds the N-1 most recent difference bits; the newest bit from the
    // cell completes the N-bit word on the final step.
    logic [N-2:0]         r_r_sh;
    logic                 r_brw_q;
    logic [N-1:0]         r_d;
    logic                 r_borrow;
    logic                 r_done;

    logic                 w_d_bit;
    logic                 w_b_out;
    logic [N-1:0]         w_r_nxt;
    logic                 w_load;
    logic                 w_last;

    // Operands may be loaded from IDLE or straight from DONE (back-to-back).
    assign w_load  = start && (r_state != RUN);
    assign w_last  = (r_state == RUN) && (r_cnt == c_cnt_last);
    assign w_r_nxt = {w_d_bit, r_r_sh};

    celda_resta u_celda (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_brw_q),
        .d     (w_d_bit),
        .c_out (w_b_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a run lasts exactly N steps, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_cnt_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Serial datapath: load operands, then one bit per clock through the cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_r_sh   <= '0;
            r_brw_q  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_brw_q  <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_r_sh   <= w_r_nxt[N-1:1];
            r_brw_q  <= w_b_out;
            r_cnt    <= r_cnt + c_cnt_w'(1);
        end
    end

    // Result registers: updated only on the completion edge, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_d      <= w_r_nxt;
                r_borrow <= w_b_out;
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = r_done;
    assign d      = r_d;
    assign borrow = r_borrow;

endmodule : restador_serial
`default_nettype wire

// File: tb/tb_restador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restador_serial
//  Description : Self-checking bench for restador_serial (N=8): directed
//                corner cases plus random operand pairs against plain
//                integer subtraction, with a scoreboard-driven monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_restador_serial;

    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         borrow;

    restador_serial #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] d;
        logic         br;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           cyc      = 0;
    int           checks   = 0;
    int           passed   = 0;
    int           last_acc = 0;

    // Monitor-owned state.
    logic [N-1:0] hold_d    = '0;
    logic         hold_br   = 1'b0;
    logic         prev_done = 1'b0;
    logic         eb_m;
    exp_t         e_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Issue one operation once the DUT can accept it; the expected result is
    // pushed with the acceptance edge. hold>0 keeps start asserted with
    // garbage operands during the run, which the DUT must ignore.
    task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int hold);
        int           n;
        logic [N-1:0] ed;
        exp_t         e;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0) begin
            n++;
            if (n > 4 * N) begin
                checks++;
                $display("FAIL start_timeout: busy stuck at %0b, expected 0", busy);
                return;
            end
            @(negedge clk);
        end
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        ed    = ta - tb_v;
        e.d   = ed;
        e.br  = (ta < tb_v);
        e.acc = cyc;
        last_acc = cyc;
        sb.push_back(e);
        for (int i = 0; i < hold; i++) begin
            a = N'($urandom); b = N'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        a = N'($urandom); b = N'($urandom);
    endtask

    // Monitor: checks busy window, done pulse width, latency, results and hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_d    = '0;
            hold_br   = 1'b0;
            prev_done = 1'b0;
            chk("rst_busy",   busy,   0);
            chk("rst_done",   done,   0);
            chk("rst_d",      d,      0);
            chk("rst_borrow", borrow, 0);
        end else begin
            eb_m = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + N);
            chk("busy", busy, eb_m);
            if (done) begin
                chk("done_width", prev_done, 0);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_done: done=1 with no operation outstanding, expected 0");
                end else begin
                    e_m = sb.pop_front();
                    chk("latency", cyc, e_m.acc + N);
                    chk("d",       d,      e_m.d);
                    chk("borrow",  borrow, e_m.br);
                    hold_d  = e_m.d;
                    hold_br = e_m.br;
                end
            end else begin
                chk("d_hold",      d,      hold_d);
                chk("borrow_hold", borrow, hold_br);
            end
            prev_done = done;
        end
    end

    initial begin
        int           acc1;
        int           sel;
        int           n;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed cases.
        start_op(8'h35, 8'h12, 0);
        start_op(8'h12, 8'h35, 0);
        start_op(8'h00, 8'h01, 0);
        start_op(8'hFF, 8'hFF, 0);
        start_op(8'h00, 8'hFF, 0);
        start_op(8'h5A, 8'h00, 0);
        // start held with changing operands during the run.
        start_op(8'hA7, 8'h3C, N - 2);

        // Back-to-back: second start lands in the DONE cycle.
        repeat (N + 3) @(posedge clk);
        start_op(8'h10, 8'h01, 0);
        acc1 = last_acc;
        start_op(8'h80, 8'h01, 0);
        chk("b2b_gap", last_acc - acc1, N + 1);

        // Asynchronous reset in the middle of a run.
        repeat (N + 3) @(posedge clk);
        start_op(8'hC3, 8'h21, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_d",    d,    0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        start_op(8'hC3, 8'h21, 0);

        // Random pairs, with forced corner operands and idle gaps mixed in.
        for (int i = 0; i < 1000; i++) begin
            ra  = N'($urandom);
            rb  = N'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = ra;
            else if (sel == 2) begin ra = '0; rb = '1; end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            start_op(ra, rb, $urandom_range(0, N - 2));
        end

        // Drain outstanding results.
        n = 0;
        while (sb.size() > 0 && n < 4 * N) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_restador_serial
`default_nettype wire
